// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants and fetch FSM state encoding.
package riscv_pipe_pkg;

   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise contents hold.
module if_id_reg
   import riscv_pipe_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   output logic [31:0] instr_rd_d,
   output logic [31:0] pc_in_d,
   output logic [31:0] pc_plus4_in_d,
   output logic        valid_d
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_rd_d    <= NOP_INSTR;
         pc_in_d       <= '0;
         pc_plus4_in_d <= '0;
         valid_d       <= 1'b0;
      end else if (bubble) begin
         instr_rd_d    <= NOP_INSTR;
         pc_in_d       <= '0;
         pc_plus4_in_d <= '0;
         valid_d       <= 1'b0;
      end else if (load) begin
         instr_rd_d    <= instr;
         pc_in_d       <= pc;
         pc_plus4_in_d <= pc + 32'd4;
         valid_d       <= 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch_stage.sv
// RISC-V fetch stage: PC_F, single-outstanding imem request FSM, hold buffer, IF/ID.
// Optional FETCH_PERF_CNT_EN adds fetch and stall performance counters.
module instr_fetch_stage
   import riscv_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        pc_src_e,
   input  logic [31:0] pc_target_e,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr_rd_d,
   output logic [31:0] pc_in_d,
   output logic [31:0] pc_plus4_in_d,
   output logic        valid_d
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc_f, hold_instr, deliver_instr;
   logic         deliver, capture, ifid_load, ifid_bubble;

   assign imem_req_valid = (state == S_REQ) && !pc_src_e;
   assign imem_addr      = pc_f & ~32'h3;

   always_comb begin
      state_nxt     = state;
      deliver       = 1'b0;
      capture       = 1'b0;
      deliver_instr = imem_rsp_data;
      case (state)
         S_REQ:  if (imem_req_valid && imem_req_ready) state_nxt = S_WAIT;
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (pc_src_e)     state_nxt = S_REQ;
               else if (stall_d) begin
                  capture   = 1'b1;
                  state_nxt = S_HOLD;
               end else begin
                  deliver   = 1'b1;
                  state_nxt = S_REQ;
               end
            end else if (pc_src_e) begin
               state_nxt = S_DROP;
            end
         end
         S_HOLD: begin
            if (pc_src_e) state_nxt = S_REQ;
            else if (!stall_d) begin
               deliver       = 1'b1;
               deliver_instr = hold_instr;
               state_nxt     = S_REQ;
            end
         end
         S_DROP: if (imem_rsp_valid) state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
   end

   // A delivery squashed by flush_d still advances PC_F; only IF/ID is bubbled.
   assign ifid_bubble = pc_src_e || flush_d || (!stall_d && !deliver);
   assign ifid_load   = deliver;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_REQ;
         pc_f       <= RESET_PC;
         hold_instr <= NOP_INSTR;
      end else begin
         state <= state_nxt;
         if (capture) hold_instr <= imem_rsp_data;
         if (pc_src_e)     pc_f <= pc_target_e & ~32'h3;
         else if (deliver) pc_f <= pc_f + 32'd4;
      end
   end

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk           (clk),
      .rst_n         (rst_n),
      .load          (ifid_load),
      .bubble        (ifid_bubble),
      .instr         (deliver_instr),
      .pc            (pc_f),
      .instr_rd_d    (instr_rd_d),
      .pc_in_d       (pc_in_d),
      .pc_plus4_in_d (pc_plus4_in_d),
      .valid_d       (valid_d)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (ifid_load && !ifid_bubble) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (stall_d)                   perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: cycle table plus drop, reset and wrap sequences.
module tb_instr_fetch_stage;
   import riscv_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
   logic [31:0] pc_target_e = '0;
   logic        imem_req_ready = 1'b1;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        imem_req_valid, valid_d;
   logic [31:0] imem_addr, instr_rd_d, pc_in_d, pc_plus4_in_d;
   logic        req2, valid2;
   logic [31:0] addr2, instr2, pc2, pc4_2;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] pf_fetch, pf_stall, pf_fetch2, pf_stall2;
`endif

   int total = 0, bad = 0;
   int mem_lat = 0;

   always #5 clk = ~clk;

   instr_fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_d(flush_d),
      .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_rd_d(instr_rd_d), .pc_in_d(pc_in_d), .pc_plus4_in_d(pc_plus4_in_d), .valid_d(valid_d)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetch_cnt(pf_fetch), .perf_stall_cnt(pf_stall)
`endif
   );

   instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_d(flush_d),
      .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
      .imem_req_valid(req2), .imem_req_ready(imem_req_ready), .imem_addr(addr2),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_rd_d(instr2), .pc_in_d(pc2), .pc_plus4_in_d(pc4_2), .valid_d(valid2)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetch_cnt(pf_fetch2), .perf_stall_cnt(pf_stall2)
`endif
   );

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return 32'hDEAD_0000 ^ a;
   endfunction

   // Memory model: zero-wait answers on the accept edge, else after mem_lat edges.
   logic        pend = 1'b0;
   int          cnt = 0;
   logic [31:0] addr_q = '0;
   always @(posedge clk) begin
      imem_rsp_valid <= 1'b0;
      if (pend) begin
         if (cnt == 0) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mdata(addr_q);
            pend           <= 1'b0;
         end else cnt <= cnt - 1;
      end
      if (imem_req_valid && imem_req_ready) begin
         if (mem_lat == 0) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mdata(imem_addr);
         end else begin
            pend   <= 1'b1;
            cnt    <= mem_lat - 1;
            addr_q <= imem_addr;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_ifid(input string nm, input logic v, input logic [31:0] pc);
      chk({nm, " valid_d"}, 32'(valid_d), 32'(v));
      if (v) begin
         chk({nm, " pc_in_d"}, pc_in_d, pc);
         chk({nm, " pc_plus4"}, pc_plus4_in_d, pc + 32'd4);
         chk({nm, " instr"}, instr_rd_d, mdata(pc));
      end else chk({nm, " instr nop"}, instr_rd_d, DEF_NOP_INSTR);
   endtask

   typedef struct {
      logic [2:0]  ctrl;     // {stall, flush, pc_src}
      logic [31:0] tgt;
      logic        rdy;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_v;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vt[38];

   function automatic vec_t mk(input logic [2:0] c, input logic [31:0] t, input logic r,
                               input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep);
      vec_t v;
      v.ctrl = c; v.tgt = t; v.rdy = r; v.exp_req = er; v.exp_addr = ea; v.exp_v = ev; v.exp_pc = ep;
      return v;
   endfunction

   initial begin
      vt[0]  = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h000, 1'b0, 32'h000);
      vt[1]  = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h000, 1'b1, 32'h000);
      vt[2]  = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h004, 1'b0, 32'h000);
      vt[3]  = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h004, 1'b1, 32'h004);
      vt[4]  = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h008, 1'b0, 32'h000);
      vt[5]  = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h008, 1'b1, 32'h008);
      vt[6]  = mk(3'b110, 32'h0,   1'b1, 1'b1, 32'h00C, 1'b0, 32'h000);
      vt[7]  = mk(3'b100, 32'h0,   1'b1, 1'b0, 32'h00C, 1'b0, 32'h000);
      vt[8]  = mk(3'b100, 32'h0,   1'b1, 1'b0, 32'h00C, 1'b0, 32'h000);
      vt[9]  = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h00C, 1'b1, 32'h00C);
      vt[10] = mk(3'b100, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h00C);
      vt[11] = mk(3'b100, 32'h0,   1'b1, 1'b0, 32'h010, 1'b1, 32'h00C);
      vt[12] = mk(3'b100, 32'h0,   1'b1, 1'b0, 32'h010, 1'b1, 32'h00C);
      vt[13] = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h010, 1'b1, 32'h010);
      vt[14] = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h014, 1'b0, 32'h000);
      vt[15] = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h014, 1'b1, 32'h014);
      vt[16] = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h018, 1'b0, 32'h000);
      vt[17] = mk(3'b010, 32'h0,   1'b1, 1'b0, 32'h018, 1'b0, 32'h000);
      vt[18] = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h01C, 1'b0, 32'h000);
      vt[19] = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h01C, 1'b1, 32'h01C);
      vt[20] = mk(3'b111, 32'h203, 1'b1, 1'b0, 32'h020, 1'b0, 32'h000);
      vt[21] = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h000);
      vt[22] = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
      for (int k = 23; k < 27; k++)
         vt[k] = mk(3'b000, 32'h0, 1'b0, 1'b1, 32'h204, 1'b0, 32'h000);
      vt[27] = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h000);
      vt[28] = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h204, 1'b1, 32'h204);
      vt[29] = mk(3'b100, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h204);
      vt[30] = mk(3'b100, 32'h0,   1'b1, 1'b0, 32'h208, 1'b1, 32'h204);
      vt[31] = mk(3'b101, 32'h300, 1'b1, 1'b0, 32'h208, 1'b0, 32'h000);
      vt[32] = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h300, 1'b0, 32'h000);
      vt[33] = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h300, 1'b1, 32'h300);
      vt[34] = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h304, 1'b0, 32'h000);
      vt[35] = mk(3'b001, 32'h400, 1'b1, 1'b0, 32'h304, 1'b0, 32'h000);
      vt[36] = mk(3'b000, 32'h0,   1'b1, 1'b1, 32'h400, 1'b0, 32'h000);
      vt[37] = mk(3'b000, 32'h0,   1'b1, 1'b0, 32'h400, 1'b1, 32'h400);

      // Reset state
      @(negedge clk);
      #1;
      chk("rst req_valid", 32'(imem_req_valid), 32'd1);
      chk("rst addr", imem_addr, 32'h0);
      chk("rst addr wrap dut", addr2, 32'hFFFF_FFFC);
      chk_ifid("rst", 1'b0, 32'h0);
      chk("rst pc_in_d", pc_in_d, 32'h0);
      chk("rst pc_plus4", pc_plus4_in_d, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 38; i++) begin
         {stall_d, flush_d, pc_src_e} = vt[i].ctrl;
         pc_target_e    = vt[i].tgt;
         imem_req_ready = vt[i].rdy;
         #1;
         chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(vt[i].exp_req));
         chk($sformatf("v%0d imem_addr", i), imem_addr, vt[i].exp_addr);
         if (i == 2) chk("wrap second addr", addr2, 32'h0);
         step();
         chk_ifid($sformatf("v%0d", i), vt[i].exp_v, vt[i].exp_pc);
         if (i == 1) begin
            chk("wrap pc_in_d", pc2, 32'hFFFF_FFFC);
            chk("wrap pc_plus4", pc4_2, 32'h0);
         end
      end
      {stall_d, flush_d, pc_src_e} = 3'b000;

      // Redirect in S_WAIT with the response still two cycles away
      mem_lat = 2;
      #1 chk("drop req", 32'(imem_req_valid), 32'd1);
      chk("drop addr", imem_addr, 32'h404);
      step();
      pc_src_e = 1'b1; pc_target_e = 32'h0000_0102;
      #1 chk("drop gated req", 32'(imem_req_valid), 32'd0);
      step();
      pc_src_e = 1'b0;
      chk_ifid("drop bubble", 1'b0, 32'h0);
      #1 chk("drop no req", 32'(imem_req_valid), 32'd0);
      step();
      chk("drop still waiting", 32'(imem_req_valid), 32'd0);
      chk_ifid("drop wait", 1'b0, 32'h0);
      step();
      mem_lat = 0;
      chk("redirect req", 32'(imem_req_valid), 32'd1);
      chk("redirect addr", imem_addr, 32'h100);
      chk_ifid("stale dropped", 1'b0, 32'h0);
      step();
      chk_ifid("redir fetch pend", 1'b0, 32'h0);
      step();
      chk_ifid("redir fetch", 1'b1, 32'h100);

      // Reset while in S_WAIT; the late response must be ignored
      mem_lat = 2;
      step();
      rst_n = 1'b0;
      imem_req_ready = 1'b0;
      #1;
      chk("mid rst req", 32'(imem_req_valid), 32'd1);
      chk("mid rst addr", imem_addr, 32'h0);
      chk("mid rst pc_in_d", pc_in_d, 32'h0);
      chk("mid rst pc_plus4", pc_plus4_in_d, 32'h0);
      chk_ifid("mid rst", 1'b0, 32'h0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_ifid($sformatf("late rsp %0d", k), 1'b0, 32'h0);
         chk("late rsp addr", imem_addr, 32'h0);
      end
      mem_lat = 0;
      imem_req_ready = 1'b1;
      step();
      chk_ifid("post rst req", 1'b0, 32'h0);
      step();
      chk_ifid("post rst fetch", 1'b1, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
